// File: rtl/serial_tx_arbiter_if.sv
// Byte request handshake between NREQ requesters and the serial transmit arbiter.
// Requester i drives req_valid[i] and req_data[8i+7:8i]; the arbiter strobes req_ready[i].
interface serial_tx_arbiter_if #(
  parameter int NREQ = 2
);
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*8-1:0] req_data;
  logic [NREQ-1:0]   req_ready;

  modport master (
    output req_valid,
    output req_data,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_data,
    output req_ready
  );
endinterface

// File: rtl/serial_tx_arbiter.sv
// Round-robin arbiter serialising NREQ byte requesters onto one tx line.
// Define SERIAL_TX_PARITY_EN to insert an even-parity bit between data and stop.
module serial_tx_arbiter #(
  parameter int NREQ      = 2,
  parameter int STOP_BITS = 1
) (
  input  logic                clk,
  input  logic                reset,
  serial_tx_arbiter_if.slave  req_if,
  output logic                tx,
  output logic                busy,
  output logic [2:0]          grant_id
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP
`ifdef SERIAL_TX_PARITY_EN
    , PARITY
`endif
  } state_t;

  localparam logic [1:0] STOP_LAST = 2'(STOP_BITS - 1);
  localparam logic [2:0] LAST_RST  = 3'(NREQ - 1);

  state_t     state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [1:0] stop_cnt_q, stop_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic       tx_q, tx_d;
  logic [2:0] grant_q, grant_d;
  logic [2:0] last_q, last_d;
`ifdef SERIAL_TX_PARITY_EN
  logic       par_q, par_d;
`endif

  logic       found;
  logic [2:0] win;
  logic [7:0] win_data;
  logic       in_win;
  logic       hs;
  int         idx;

  // Scan starts just after the last winner, wrapping at NREQ.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int i = 1; i <= NREQ; i++) begin
      idx = int'(last_q) + i;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && req_if.req_valid[idx]) begin
        found = 1'b1;
        win   = 3'(idx);
      end
    end
  end

  always_comb begin
    win_data = '0;
    for (int j = 0; j < NREQ; j++) begin
      if (win == 3'(j)) win_data = req_if.req_data[j*8 +: 8];
    end
  end

  assign in_win = (state_q == IDLE) ||
                  ((state_q == STOP) && (stop_cnt_q == STOP_LAST));
  assign hs     = in_win && found && !reset;

  always_comb begin
    req_if.req_ready = '0;
    for (int j = 0; j < NREQ; j++) begin
      req_if.req_ready[j] = hs && (win == 3'(j));
    end
  end

  // tx_d is the bit the line carries in the cycle after this one.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    shift_d    = shift_q;
    tx_d       = tx_q;
    grant_d    = grant_q;
    last_d     = last_q;
`ifdef SERIAL_TX_PARITY_EN
    par_d      = par_q;
`endif
    unique case (state_q)
      IDLE: tx_d = 1'b1;
      START: begin
        state_d   = DATA;
        bit_cnt_d = 3'd0;
        tx_d      = shift_q[0];
        shift_d   = shift_q >> 1;
      end
      DATA: begin
        if (bit_cnt_q == 3'd7) begin
`ifdef SERIAL_TX_PARITY_EN
          state_d = PARITY;
          tx_d    = par_q;
`else
          state_d    = STOP;
          stop_cnt_d = 2'd0;
          tx_d       = 1'b1;
`endif
        end else begin
          bit_cnt_d = bit_cnt_q + 3'd1;
          tx_d      = shift_q[0];
          shift_d   = shift_q >> 1;
        end
      end
`ifdef SERIAL_TX_PARITY_EN
      PARITY: begin
        state_d    = STOP;
        stop_cnt_d = 2'd0;
        tx_d       = 1'b1;
      end
`endif
      STOP: begin
        if (stop_cnt_q == STOP_LAST) begin
          state_d = IDLE;
          tx_d    = 1'b1;
        end else begin
          stop_cnt_d = stop_cnt_q + 2'd1;
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
    if (hs) begin
      state_d = START;
      tx_d    = 1'b0;
      shift_d = win_data;
      grant_d = win;
      last_d  = win;
`ifdef SERIAL_TX_PARITY_EN
      par_d   = ^win_data;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      stop_cnt_q <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
      grant_q    <= '0;
      last_q     <= LAST_RST;
`ifdef SERIAL_TX_PARITY_EN
      par_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      grant_q    <= grant_d;
      last_q     <= last_d;
`ifdef SERIAL_TX_PARITY_EN
      par_q      <= par_d;
`endif
    end
  end

  assign tx       = tx_q;
  assign busy     = (state_q != IDLE);
  assign grant_id = grant_q;

endmodule

// File: tb/tb_serial_tx_arbiter.sv
// Bench for serial_tx_arbiter: directed scenarios then random traffic,
// every cycle compared with a queue-of-line-bits reference model.
module tb_serial_tx_arbiter;

  localparam int NREQ      = 3;
  localparam int STOP_BITS = 1;

  logic       clk = 1'b0;
  logic       reset;
  logic       tx;
  logic       busy;
  logic [2:0] grant_id;

  serial_tx_arbiter_if #(.NREQ(NREQ)) bus ();

  serial_tx_arbiter #(
    .NREQ(NREQ),
    .STOP_BITS(STOP_BITS)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req_if(bus),
    .tx(tx),
    .busy(busy),
    .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  bit             line [$];
  logic [7:0]     src [NREQ][$];
  logic [NREQ-1:0] wd;
  logic [NREQ-1:0] obs_ready;
  bit             rnd_mode;
  int             m_last;
  int             m_gid;
  int             dut_hs;
  int             checks;
  int             errors;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      wd[i] = rnd_mode ? ($urandom_range(7) == 0) : 1'b0;
      bus.req_valid[i] = (src[i].size() > 0) && !wd[i];
      bus.req_data[i*8 +: 8] = (src[i].size() > 0) ? src[i][0] : 8'h00;
    end
  endtask

  task automatic step();
    int              win;
    bit              anyv;
    logic [NREQ-1:0] ev;
    logic [7:0]      d;
    @(negedge clk);
    anyv = 1'b0;
    win  = 0;
    for (int k = 1; k <= NREQ; k++) begin
      if (!anyv && bus.req_valid[(m_last + k) % NREQ]) begin
        anyv = 1'b1;
        win  = (m_last + k) % NREQ;
      end
    end
    ev = '0;
    if (!reset && line.size() <= 1 && anyv) ev[win] = 1'b1;
    obs_ready = bus.req_ready;
    if (obs_ready != 0) dut_hs++;
    chk("tx", 32'(tx), 32'((line.size() > 0) ? line[0] : 1'b1));
    chk("busy", 32'(busy), 32'(line.size() > 0));
    chk("grant_id", 32'(grant_id), 32'(m_gid));
    chk("req_ready", 32'(bus.req_ready), 32'(ev));
    if (reset) begin
      line.delete();
      m_last = NREQ - 1;
      m_gid  = 0;
    end else begin
      if (line.size() > 0) void'(line.pop_front());
      if (ev != 0) begin
        d = src[win].pop_front();
        line.push_back(1'b0);
        for (int b = 0; b < 8; b++) line.push_back(d[b]);
`ifdef SERIAL_TX_PARITY_EN
        line.push_back(^d);
`endif
        for (int s = 0; s < STOP_BITS; s++) line.push_back(1'b1);
        m_last = win;
        m_gid  = win;
      end
    end
    @(posedge clk);
    #1;
    drive();
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    dut_hs   = 0;
    rnd_mode = 1'b0;
    m_last   = NREQ - 1;
    m_gid    = 0;
    reset    = 1'b1;
    src[0].push_back(8'hA5);
    drive();
    run(3);

    reset = 1'b0;
    step();
    chk("t1_first_ready", 32'(obs_ready), 32'd1);
    run(14);
    chk("t1_grant", 32'(grant_id), 32'd0);
    chk("t1_idle_tx", 32'(tx), 32'd1);

    for (int n = 0; n < 4; n++) begin
      src[0].push_back(8'h11);
      src[1].push_back(8'h22);
    end
    drive();
    dut_hs = 0;
    run(8 * (9 + STOP_BITS) + 10);
    chk("t2_handshakes", 32'(dut_hs), 32'd8);

    src[1].push_back(8'h00);
    src[1].push_back(8'hFF);
    src[1].push_back(8'h80);
    drive();
    dut_hs = 0;
    run(3 * (9 + STOP_BITS) + 8);
    chk("t3_handshakes", 32'(dut_hs), 32'd3);
    chk("t3_grant", 32'(grant_id), 32'd1);

    src[1].push_back(8'h3C);
    drive();
    run(5);
    src[0].push_back(8'h5A);
    src[1].push_back(8'h77);
    reset = 1'b1;
    drive();
    run(2);
    chk("t4_busy_in_reset", 32'(busy), 32'd0);
    reset = 1'b0;
    step();
    chk("t4_ptr_reset", 32'(obs_ready), 32'd1);
    run(30);

    rnd_mode = 1'b1;
    repeat (600) begin
      if ($urandom_range(3) == 0) begin
        int q;
        q = $urandom_range(NREQ - 1);
        if (src[q].size() < 3) src[q].push_back(8'($urandom));
      end
      reset = ($urandom_range(149) == 0);
      step();
    end

    rnd_mode = 1'b0;
    reset    = 1'b0;
    drive();
    run(NREQ * 3 * 15 + 20);
    chk("drain_busy", 32'(busy), 32'd0);
    chk("drain_tx", 32'(tx), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
